// File: rtl/mux_rr_stream_pkg.sv
// -----------------------------------------------------------------------------
// mux_defs
// Shared definitions for the stream multiplexer slice.
//   MUX_MODE_SEL : channel picked by the external sel input
//   MUX_MODE_RR  : channel picked by round-robin arbitration
//   clog2()      : ceiling log2, used to size select/tag fields
// -----------------------------------------------------------------------------
package mux_defs;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Smallest r with 2**r >= value; value is expected to be >= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_rr_stream_dec_onehot.sv
// -----------------------------------------------------------------------------
// dec_onehot
// N-way one-hot decoder with enable. Output bit idx is high when en is high;
// all bits are low when en is low or idx does not name one of the N outputs.
//   idx    : index to decode
//   en     : decoder enable
//   onehot : decoded output, at most one bit set
// -----------------------------------------------------------------------------
module dec_onehot #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    // Compare the index against every output position.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            onehot[k] = en && (idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// -----------------------------------------------------------------------------
// mux_rr_stream
// CHANNELS-way valid/ready stream multiplexer with a one-entry registered
// output stage. The channel is chosen by sel (MODE=MUX_MODE_SEL) or by
// round-robin arbitration (MODE=MUX_MODE_RR). Each stored word carries the
// index of the channel it came from.
//   clk, reset : clock and asynchronous active-high reset
//   in_data    : packed input words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero, combinational
//   sel        : external channel select (select mode only)
//   out_data   : registered selected word
//   out_chan   : registered source channel of out_data
//   out_valid  : output stage holds a word
//   out_ready  : downstream accept
// -----------------------------------------------------------------------------
module mux_rr_stream
    import mux_defs::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = MUX_MODE_SEL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    input  logic [clog2(CHANNELS)-1:0] sel,
    output logic [WIDTH-1:0]           out_data,
    output logic [clog2(CHANNELS)-1:0] out_chan,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int SEL_W = clog2(CHANNELS);
    localparam logic [SEL_W:0] CH_EXT = (SEL_W + 1)'(CHANNELS);

    logic                  load_en_s;
    logic                  ready_en_s;
    logic                  xfer_s;
    logic [WIDTH-1:0]      word_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic                  grant_valid_s;
    logic                  sel_hit_s;
    logic [SEL_W-1:0]      ptr_r;
    logic [SEL_W-1:0]      ptr_next_s;
    logic [2*CHANNELS-1:0] dbl_valid_s;
    logic [CHANNELS-1:0]   rot_valid_s;
    logic [SEL_W-1:0]      rr_pos_s;
    logic [SEL_W:0]        rr_sum_s;
    logic [SEL_W-1:0]      rr_idx_s;
    logic                  rr_found_s;

    // The output stage can take a word when empty or being drained this cycle.
    assign load_en_s  = !out_valid || out_ready;
    // Reset gating keeps in_ready low for the whole reset window.
    assign ready_en_s = load_en_s && grant_valid_s && !reset;
    assign xfer_s     = |(in_valid & in_ready);

    // Select-mode grant: sel must name an existing channel that is valid.
    always_comb begin
        sel_hit_s = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hit_s = sel_hit_s | ((sel == SEL_W'(k)) && in_valid[k]);
        end
    end

    // Round-robin search: rotate so ptr sits at bit 0, take the lowest set
    // bit, then rotate the winning position back to a channel index.
    always_comb begin
        dbl_valid_s = {in_valid, in_valid} >> ptr_r;
        rot_valid_s = dbl_valid_s[CHANNELS-1:0];
        rr_pos_s    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            rr_pos_s = rot_valid_s[i] ? SEL_W'(i) : rr_pos_s;
        end
        rr_found_s = |rot_valid_s;
        rr_sum_s   = {1'b0, rr_pos_s} + {1'b0, ptr_r};
        rr_sum_s   = (rr_sum_s >= CH_EXT) ? (rr_sum_s - CH_EXT) : rr_sum_s;
        rr_idx_s   = rr_sum_s[SEL_W-1:0];
        ptr_next_s = (rr_idx_s == SEL_W'(CHANNELS - 1)) ? '0 : (rr_idx_s + SEL_W'(1));
    end

    // Pick the grant source for the configured mode.
    always_comb begin
        if (MODE == MUX_MODE_RR) begin
            grant_idx_s   = rr_idx_s;
            grant_valid_s = rr_found_s;
        end else begin
            grant_idx_s   = sel;
            grant_valid_s = sel_hit_s;
        end
    end

    dec_onehot #(
        .N     (CHANNELS),
        .IDX_W (SEL_W)
    ) u_ready_dec (
        .idx    (grant_idx_s),
        .en     (ready_en_s),
        .onehot (in_ready)
    );

    // AND-OR data mux steered by the one-hot ready vector.
    always_comb begin
        word_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            word_s = word_s | (in_data[k*WIDTH +: WIDTH] & {WIDTH{in_ready[k]}});
        end
    end

    // One-entry output stage: load on transfer, clear valid on drain, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= word_s;
            out_chan  <= grant_idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Round-robin pointer moves past the winner only when a word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (xfer_s && (MODE == MUX_MODE_RR)) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // select-mode, 4 channels
    logic [31:0] s_in_data;
    logic [3:0]  s_in_valid, s_in_ready;
    logic [1:0]  s_sel, s_out_chan;
    logic [7:0]  s_out_data;
    logic        s_out_valid, s_out_ready;
    // round-robin, 4 channels
    logic [31:0] r_in_data;
    logic [3:0]  r_in_valid, r_in_ready;
    logic [1:0]  r_sel, r_out_chan;
    logic [7:0]  r_out_data;
    logic        r_out_valid, r_out_ready;
    // select-mode, 3 channels
    logic [23:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_out_chan;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready;

    always #5 clk = ~clk;

    mux_rr_stream #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_sel (
        .clk(clk), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .sel(s_sel), .out_data(s_out_data),
        .out_chan(s_out_chan), .out_valid(s_out_valid), .out_ready(s_out_ready));

    mux_rr_stream #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
        .out_chan(r_out_chan), .out_valid(r_out_valid), .out_ready(r_out_ready));

    mux_rr_stream #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_c3 (
        .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready));

    task automatic do_reset();
        reset = 1'b1;
        s_in_valid = '0; r_in_valid = '0; c_in_valid = '0;
        s_out_ready = 1'b1; r_out_ready = 1'b1; c_out_ready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r_in_data = 32'h44A52211; r_in_valid = 4'hF; r_out_ready = 1'b0;
        s_in_data = 32'h44332211; s_in_valid = 4'hF; s_sel = 2'd0; s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({r_out_valid, r_out_data, r_out_chan} !== 11'd0) begin
            bad++; $display("FAIL reset_outputs: got %b/%h/%0d want 0/00/0", r_out_valid, r_out_data, r_out_chan);
        end
        total++;
        if (r_in_ready !== 4'h0 || s_in_ready !== 4'h0) begin
            bad++; $display("FAIL reset_in_ready: got rr=%b sel=%b want 0000", r_in_ready, s_in_ready);
        end
        // load 0xA5 from channel 2, then hold it under back-pressure
        r_in_valid = 4'b0100;
        s_in_valid = 4'h0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({r_out_valid, r_out_data, r_out_chan} !== {1'b1, 8'hA5, 2'd2}) begin
            bad++; $display("FAIL reset_preload: got %b/%h/%0d want 1/a5/2", r_out_valid, r_out_data, r_out_chan);
        end
        #1;
        r_in_valid = 4'hF;
        reset = 1'b1;
        #1;
        total++;
        if ({r_out_valid, r_out_data, r_out_chan} !== 11'd0) begin
            bad++; $display("FAIL reset_async_clear: got %b/%h/%0d want 0/00/0", r_out_valid, r_out_data, r_out_chan);
        end
        total++;
        if (r_in_ready !== 4'h0) begin
            bad++; $display("FAIL reset_async_ready: got %b want 0000", r_in_ready);
        end
        #1;
        reset = 1'b0;
        r_out_ready = 1'b1;
        #1;
        total++;
        if (r_in_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_first_grant_ready: got %b want 0001", r_in_ready);
        end
        @(negedge clk);
        total++;
        if ({r_out_valid, r_out_data, r_out_chan} !== {1'b1, 8'h11, 2'd0}) begin
            bad++; $display("FAIL reset_first_grant: got %b/%h/%0d want 1/11/0", r_out_valid, r_out_data, r_out_chan);
        end
    endtask

    task automatic test_select_sweep();
        logic [1:0] seltab [7];
        logic [3:0] vtab [7];
        logic [3:0] rtab [7];
        exp_t e;
        seltab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0};
        vtab   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'h0, 4'h0};
        rtab   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
        do_reset();
        s_in_data = 32'h44332211;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            s_sel = seltab[i]; s_in_valid = vtab[i];
            @(negedge clk);
            total++;
            if (s_out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL sel_out_valid cyc%0d: got %b want %b", i, s_out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if ({s_out_chan, s_out_data} !== sb[0]) begin
                    bad++; $display("FAIL sel_word cyc%0d: got %0d/%h want %0d/%h", i, s_out_chan, s_out_data, sb[0].chan, sb[0].data);
                end
                if (s_out_ready) void'(sb.pop_front());
            end
            total++;
            if (s_in_ready !== rtab[i]) begin
                bad++; $display("FAIL sel_in_ready cyc%0d: got %b want %b", i, s_in_ready, rtab[i]);
            end
            if (rtab[i] != 4'h0) begin
                e.chan = 2'($clog2(rtab[i]));
                e.data = s_in_data[$clog2(rtab[i])*8 +: 8];
                sb.push_back(e);
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sel_leftover: got %0d words pending want 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] vtab [8];
        logic [3:0] rtab [8];
        exp_t e;
        vtab = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        rtab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h0, 4'h0};
        do_reset();
        r_in_data = 32'h44332211;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            r_in_valid = vtab[i];
            @(negedge clk);
            total++;
            if (r_out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL rr_out_valid cyc%0d: got %b want %b", i, r_out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if ({r_out_chan, r_out_data} !== sb[0]) begin
                    bad++; $display("FAIL rr_word cyc%0d: got %0d/%h want %0d/%h", i, r_out_chan, r_out_data, sb[0].chan, sb[0].data);
                end
                if (r_out_ready) void'(sb.pop_front());
            end
            total++;
            if (r_in_ready !== rtab[i]) begin
                bad++; $display("FAIL rr_in_ready cyc%0d: got %b want %b", i, r_in_ready, rtab[i]);
            end
            if (rtab[i] != 4'h0) begin
                e.chan = 2'($clog2(rtab[i]));
                e.data = r_in_data[$clog2(rtab[i])*8 +: 8];
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_sparse_rr();
        logic [3:0] vtab [6];
        logic [3:0] rtab [6];
        exp_t e;
        vtab = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0};
        rtab = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h0, 4'h0};
        do_reset();
        r_in_data = 32'h44332211;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            r_in_valid = vtab[i];
            @(negedge clk);
            total++;
            if (r_out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL sparse_out_valid cyc%0d: got %b want %b", i, r_out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if ({r_out_chan, r_out_data} !== sb[0]) begin
                    bad++; $display("FAIL sparse_word cyc%0d: got %0d/%h want %0d/%h", i, r_out_chan, r_out_data, sb[0].chan, sb[0].data);
                end
                if (r_out_ready) void'(sb.pop_front());
            end
            total++;
            if (r_in_ready !== rtab[i]) begin
                bad++; $display("FAIL sparse_in_ready cyc%0d: got %b want %b", i, r_in_ready, rtab[i]);
            end
            if (rtab[i] != 4'h0) begin
                e.chan = 2'($clog2(rtab[i]));
                e.data = r_in_data[$clog2(rtab[i])*8 +: 8];
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] vtab [7];
        logic       otab [7];
        logic [3:0] rtab [7];
        exp_t e;
        vtab = '{4'h4, 4'h2, 4'hF, 4'h2, 4'h2, 4'h0, 4'h0};
        otab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rtab = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
        do_reset();
        r_in_data = 32'h445A7711;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            r_in_valid = vtab[i];
            r_out_ready = otab[i];
            if (i == 2) r_in_data[23:16] = 8'hEE;
            @(negedge clk);
            total++;
            if (r_out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL bp_out_valid cyc%0d: got %b want %b", i, r_out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if ({r_out_chan, r_out_data} !== sb[0]) begin
                    bad++; $display("FAIL bp_word cyc%0d: got %0d/%h want %0d/%h", i, r_out_chan, r_out_data, sb[0].chan, sb[0].data);
                end
                if (r_out_ready) void'(sb.pop_front());
            end
            total++;
            if (r_in_ready !== rtab[i]) begin
                bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", i, r_in_ready, rtab[i]);
            end
            if (rtab[i] != 4'h0) begin
                e.chan = 2'($clog2(rtab[i]));
                e.data = r_in_data[$clog2(rtab[i])*8 +: 8];
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_invalid_select();
        logic [1:0] seltab [7];
        logic [2:0] rtab [7];
        exp_t e;
        seltab = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3};
        rtab   = '{3'h2, 3'h0, 3'h0, 3'h0, 3'h4, 3'h0, 3'h0};
        do_reset();
        c_in_data = 24'h332211;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            c_sel = seltab[i];
            c_in_valid = 3'h7;
            @(negedge clk);
            total++;
            if (c_out_valid !== (sb.size() != 0)) begin
                bad++; $display("FAIL inv_out_valid cyc%0d: got %b want %b", i, c_out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if ({c_out_chan, c_out_data} !== sb[0]) begin
                    bad++; $display("FAIL inv_word cyc%0d: got %0d/%h want %0d/%h", i, c_out_chan, c_out_data, sb[0].chan, sb[0].data);
                end
                if (c_out_ready) void'(sb.pop_front());
            end
            total++;
            if (c_in_ready !== rtab[i]) begin
                bad++; $display("FAIL inv_in_ready cyc%0d: got %b want %b", i, c_in_ready, rtab[i]);
            end
            if (rtab[i] != 3'h0) begin
                e.chan = 2'($clog2(rtab[i]));
                e.data = c_in_data[$clog2(rtab[i])*8 +: 8];
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        s_in_data = '0; s_in_valid = '0; s_sel = '0; s_out_ready = 1'b1;
        r_in_data = '0; r_in_valid = '0; r_sel = '0; r_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;
        test_reset();
        test_select_sweep();
        test_round_robin();
        test_sparse_rr();
        test_back_pressure();
        test_invalid_select();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
